// File: rtl/sw_cmd_pulse_ctrl_pkg.sv
// sw_cmd_pkg: shared types and helpers for the software command sequencer.
// The channel state enum, the counter width derivation and the channel limit live here.
`timescale 1ns/1ps
package sw_cmd_pkg;

  // Upper bound on the number of command channels a single controller may carry
  localparam int MAX_CH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERR
  } state_t;

  // Counter width large enough to hold the larger of the pulse length and the timeout
  function automatic int cntWidth(input int pulseLen, input int timeoutCyc);
    int maxVal;
    maxVal = (pulseLen > timeoutCyc) ? pulseLen : timeoutCyc;
    return $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/sw_cmd_pulse_ctrl_if.sv
// sw_cmd_pulse_ctrl_if: per-channel request/rearm/ack inputs and pulse/status outputs.
// master is the Nios/downstream side, slave is the sequencer itself.
`timescale 1ns/1ps
interface sw_cmd_pulse_ctrl_if #(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0] cmd_req;
  logic [NUM_CH-1:0] cmd_rearm;
  logic [NUM_CH-1:0] cmd_ack;
  logic [NUM_CH-1:0] cmd_pulse;
  logic [NUM_CH-1:0] cmd_busy;
  logic [NUM_CH-1:0] cmd_done;
  logic [NUM_CH-1:0] cmd_err;

  modport master (
    output cmd_req, cmd_rearm, cmd_ack,
    input  cmd_pulse, cmd_busy, cmd_done, cmd_err
  );

  modport slave (
    input  cmd_req, cmd_rearm, cmd_ack,
    output cmd_pulse, cmd_busy, cmd_done, cmd_err
  );
endinterface

// File: rtl/sw_cmd_pulse_ctrl_channel.sv
// sw_cmd_channel: one command channel (IDLE/PULSE/WAIT_ACK/DONE/ERR).
// Turns a level request into a PULSE_LEN-cycle pulse, waits for the acknowledge and
// latches done (or error) until rearmed. Optional macro SW_CMD_TIMEOUT_EN adds the
// WAIT_ACK timeout to ERR; without it the channel waits for the ack indefinitely.
`timescale 1ns/1ps
module sw_cmd_channel
  import sw_cmd_pkg::*;
#(
  parameter int PULSE_LEN   = 1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic i_rearm,
  input  logic i_ack,
  output logic o_pulse,
  output logic o_busy,
  output logic o_done,
  output logic o_err
);

  localparam int              CNT_W      = cntWidth(PULSE_LEN, TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_pulseCnt;
  logic             r_ackSeen;
  logic             r_pulse;
  logic             r_busy;
  logic             r_done;

`ifdef SW_CMD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] r_toCnt;
  logic             r_err;
`endif

  // Channel FSM with counters; reset and rearm both force a clean IDLE
  always_ff @(posedge clk) begin
    if (reset || i_rearm) begin
      r_state    <= ST_IDLE;
      r_pulseCnt <= '0;
      r_ackSeen  <= 1'b0;
      r_pulse    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef SW_CMD_TIMEOUT_EN
      r_toCnt    <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_state    <= ST_PULSE;
            r_pulseCnt <= PULSE_LOAD;
            r_ackSeen  <= 1'b0;
            r_pulse    <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (i_ack) begin
            r_ackSeen <= 1'b1;
          end
          if (r_pulseCnt == '0) begin
            r_pulse <= 1'b0;
            if (r_ackSeen || i_ack) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_WAIT_ACK;
`ifdef SW_CMD_TIMEOUT_EN
              r_toCnt <= '0;
`endif
            end
          end else begin
            r_pulseCnt <= r_pulseCnt - CNT_W'(1);
          end
        end
        ST_WAIT_ACK: begin
          if (i_ack) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
`ifdef SW_CMD_TIMEOUT_EN
          else if (r_toCnt == TIMEOUT_LAST) begin
            r_state <= ST_ERR;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_toCnt <= r_toCnt + CNT_W'(1);
          end
`endif
        end
        ST_DONE, ST_ERR: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
          r_pulse <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_pulse = r_pulse;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
`ifdef SW_CMD_TIMEOUT_EN
  assign o_err   = r_err;
`else
  assign o_err   = 1'b0;
`endif

endmodule

// File: rtl/sw_cmd_pulse_ctrl.sv
// sw_cmd_pulse_ctrl: NUM_CH independent software command channels between the Nios
// control registers and the CCD capture/run logic. Optional macro SW_CMD_TIMEOUT_EN
// enables the acknowledge timeout in every channel.
`timescale 1ns/1ps
module sw_cmd_pulse_ctrl
  import sw_cmd_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int PULSE_LEN   = 1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                 clk,
  input  logic                 reset,
  sw_cmd_pulse_ctrl_if.slave   cmdBus
);

  logic [NUM_CH-1:0] w_pulse;
  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_done;
  logic [NUM_CH-1:0] w_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sw_cmd_channel #(
      .PULSE_LEN   (PULSE_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_channel (
      .clk     (clk),
      .reset   (reset),
      .i_req   (cmdBus.cmd_req[g]),
      .i_rearm (cmdBus.cmd_rearm[g]),
      .i_ack   (cmdBus.cmd_ack[g]),
      .o_pulse (w_pulse[g]),
      .o_busy  (w_busy[g]),
      .o_done  (w_done[g]),
      .o_err   (w_err[g])
    );
  end

  assign cmdBus.cmd_pulse = w_pulse;
  assign cmdBus.cmd_busy  = w_busy;
  assign cmdBus.cmd_done  = w_done;
  assign cmdBus.cmd_err   = w_err;

endmodule

// File: tb/tb_sw_cmd_pulse_ctrl.sv
// tb_sw_cmd_pulse_ctrl: directed checks on two controller instances sharing one clock.
// busA: NUM_CH=4, PULSE_LEN=3, TIMEOUT_CYC=5. busB: NUM_CH=2, PULSE_LEN=4, TIMEOUT_CYC=5.
// Timeout expectations follow SW_CMD_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_sw_cmd_pulse_ctrl;

  logic clk;
  logic reset;
  int   vecCount;
  int   missCount;

  sw_cmd_pulse_ctrl_if #(.NUM_CH(4)) busA ();
  sw_cmd_pulse_ctrl_if #(.NUM_CH(2)) busB ();

  sw_cmd_pulse_ctrl #(.NUM_CH(4), .PULSE_LEN(3), .TIMEOUT_CYC(5)) dutA (
    .clk    (clk),
    .reset  (reset),
    .cmdBus (busA)
  );

  sw_cmd_pulse_ctrl #(.NUM_CH(2), .PULSE_LEN(4), .TIMEOUT_CYC(5)) dutB (
    .clk    (clk),
    .reset  (reset),
    .cmdBus (busB)
  );

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance a number of clock edges, landing 1 ns after the last one
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    vecCount++;
    assert (observed === expected) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Linear directed sequence
  initial begin
    vecCount  = 0;
    missCount = 0;
    reset = 1'b1;
    busA.cmd_req = '0; busA.cmd_rearm = '0; busA.cmd_ack = '0;
    busB.cmd_req = '0; busB.cmd_rearm = '0; busB.cmd_ack = '0;
    applyStimulus(2);
    checkOutput("rstA_pulse", busA.cmd_pulse, 4'b0000);
    checkOutput("rstA_busy",  busA.cmd_busy,  4'b0000);
    checkOutput("rstA_done",  busA.cmd_done,  4'b0000);
    checkOutput("rstA_err",   busA.cmd_err,   4'b0000);
    checkOutput("rstB_pulse", {2'b00, busB.cmd_pulse}, 4'b0000);
    checkOutput("rstB_busy",  {2'b00, busB.cmd_busy},  4'b0000);
    checkOutput("rstB_done",  {2'b00, busB.cmd_done},  4'b0000);
    checkOutput("rstB_err",   {2'b00, busB.cmd_err},   4'b0000);
    reset = 1'b0;
    applyStimulus(1);

    // A ch0: three-cycle pulse, then WAIT_ACK, ack, held req gives no refire
    busA.cmd_req = 4'b0001;
    applyStimulus(1);
    checkOutput("A_p1_pulse", busA.cmd_pulse, 4'b0001);
    checkOutput("A_p1_busy",  busA.cmd_busy,  4'b0001);
    applyStimulus(1);
    checkOutput("A_p2_pulse", busA.cmd_pulse, 4'b0001);
    applyStimulus(1);
    checkOutput("A_p3_pulse", busA.cmd_pulse, 4'b0001);
    checkOutput("A_p3_busy",  busA.cmd_busy,  4'b0001);
    applyStimulus(1);
    checkOutput("A_w1_pulse", busA.cmd_pulse, 4'b0000);
    checkOutput("A_w1_busy",  busA.cmd_busy,  4'b0001);
    checkOutput("A_w1_done",  busA.cmd_done,  4'b0000);
    applyStimulus(1);
    checkOutput("A_w2_pulse", busA.cmd_pulse, 4'b0000);
    busA.cmd_ack = 4'b0001;
    applyStimulus(1);
    checkOutput("A_ack_done", busA.cmd_done,  4'b0001);
    checkOutput("A_ack_busy", busA.cmd_busy,  4'b0000);
    busA.cmd_ack = 4'b0000;
    applyStimulus(2);
    checkOutput("A_hold_pulse", busA.cmd_pulse, 4'b0000);
    checkOutput("A_hold_done",  busA.cmd_done,  4'b0001);

    // Rearm with req still high: IDLE first, fresh pulse once rearm drops
    busA.cmd_rearm = 4'b0001;
    applyStimulus(1);
    checkOutput("A_rearm_done",  busA.cmd_done,  4'b0000);
    checkOutput("A_rearm_pulse", busA.cmd_pulse, 4'b0000);
    checkOutput("A_rearm_busy",  busA.cmd_busy,  4'b0000);
    busA.cmd_rearm = 4'b0000;
    applyStimulus(1);
    checkOutput("A_refire_pulse", busA.cmd_pulse, 4'b0001);
    checkOutput("A_refire_busy",  busA.cmd_busy,  4'b0001);
    busA.cmd_req   = 4'b0000;
    busA.cmd_rearm = 4'b0001;
    applyStimulus(1);
    checkOutput("A_abort_pulse", busA.cmd_pulse, 4'b0000);
    checkOutput("A_abort_busy",  busA.cmd_busy,  4'b0000);
    busA.cmd_rearm = 4'b0000;
    applyStimulus(1);
    checkOutput("A_idle_pulse", busA.cmd_pulse, 4'b0000);

    // A ch1 and ch3 together, ch1 rearmed mid-pulse, ch3 acked in its last pulse cycle
    busA.cmd_req = 4'b1010;
    applyStimulus(1);
    checkOutput("A_mc1_pulse", busA.cmd_pulse, 4'b1010);
    busA.cmd_req   = 4'b1000;
    busA.cmd_rearm = 4'b0010;
    applyStimulus(1);
    checkOutput("A_mc2_pulse", busA.cmd_pulse, 4'b1000);
    checkOutput("A_mc2_busy",  busA.cmd_busy,  4'b1000);
    busA.cmd_rearm = 4'b0000;
    applyStimulus(1);
    checkOutput("A_mc3_pulse", busA.cmd_pulse, 4'b1000);
    busA.cmd_ack = 4'b1010;
    applyStimulus(1);
    checkOutput("A_mc_end_pulse", busA.cmd_pulse, 4'b0000);
    checkOutput("A_mc_end_busy",  busA.cmd_busy,  4'b0000);
    checkOutput("A_mc_end_done",  busA.cmd_done,  4'b1000);
    busA.cmd_ack = 4'b0000;
    busA.cmd_req = 4'b0000;
    applyStimulus(1);
    checkOutput("A_mc_hold_done", busA.cmd_done, 4'b1000);

    // B ch0: ack in the 2nd of four pulse cycles goes straight to DONE
    busB.cmd_req = 2'b01;
    applyStimulus(1);
    checkOutput("B_ap1_pulse", {2'b00, busB.cmd_pulse}, 4'b0001);
    busB.cmd_req = 2'b00;
    applyStimulus(1);
    busB.cmd_ack = 2'b01;
    applyStimulus(1);
    checkOutput("B_ap3_pulse", {2'b00, busB.cmd_pulse}, 4'b0001);
    busB.cmd_ack = 2'b00;
    applyStimulus(1);
    checkOutput("B_ap4_pulse", {2'b00, busB.cmd_pulse}, 4'b0001);
    checkOutput("B_ap4_busy",  {2'b00, busB.cmd_busy},  4'b0001);
    applyStimulus(1);
    checkOutput("B_ap_end_pulse", {2'b00, busB.cmd_pulse}, 4'b0000);
    checkOutput("B_ap_end_busy",  {2'b00, busB.cmd_busy},  4'b0000);
    checkOutput("B_ap_end_done",  {2'b00, busB.cmd_done},  4'b0001);

    // B ch1: reset during the second pulse cycle
    busB.cmd_req = 2'b10;
    applyStimulus(1);
    checkOutput("B_rp1_pulse", {2'b00, busB.cmd_pulse}, 4'b0010);
    checkOutput("B_rp1_done",  {2'b00, busB.cmd_done},  4'b0001);
    busB.cmd_req = 2'b00;
    applyStimulus(1);
    checkOutput("B_rp2_pulse", {2'b00, busB.cmd_pulse}, 4'b0010);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("B_rst_pulse", {2'b00, busB.cmd_pulse}, 4'b0000);
    checkOutput("B_rst_busy",  {2'b00, busB.cmd_busy},  4'b0000);
    checkOutput("B_rst_done",  {2'b00, busB.cmd_done},  4'b0000);
    checkOutput("A_rst_done",  busA.cmd_done,           4'b0000);
    reset = 1'b0;
    applyStimulus(1);
    checkOutput("B_post_rst_pulse", {2'b00, busB.cmd_pulse}, 4'b0000);

    // B ch0: no ack for five WAIT_ACK cycles
    busB.cmd_req = 2'b01;
    applyStimulus(1);
    busB.cmd_req = 2'b00;
    applyStimulus(4);
    checkOutput("B_to_w1_pulse", {2'b00, busB.cmd_pulse}, 4'b0000);
    checkOutput("B_to_w1_busy",  {2'b00, busB.cmd_busy},  4'b0001);
    applyStimulus(4);
    checkOutput("B_to_w5_busy", {2'b00, busB.cmd_busy}, 4'b0001);
    checkOutput("B_to_w5_err",  {2'b00, busB.cmd_err},  4'b0000);
    applyStimulus(1);
`ifdef SW_CMD_TIMEOUT_EN
    checkOutput("B_to_err",  {2'b00, busB.cmd_err},  4'b0001);
    checkOutput("B_to_busy", {2'b00, busB.cmd_busy}, 4'b0000);
    checkOutput("B_to_done", {2'b00, busB.cmd_done}, 4'b0000);
`else
    checkOutput("B_noto_err",  {2'b00, busB.cmd_err},  4'b0000);
    checkOutput("B_noto_busy", {2'b00, busB.cmd_busy}, 4'b0001);
`endif
    busB.cmd_rearm = 2'b01;
    applyStimulus(1);
    checkOutput("B_to_rearm_err",  {2'b00, busB.cmd_err},  4'b0000);
    checkOutput("B_to_rearm_busy", {2'b00, busB.cmd_busy}, 4'b0000);
    busB.cmd_rearm = 2'b00;

    // B ch0: ack on the same edge as timeout expiry
    busB.cmd_req = 2'b01;
    applyStimulus(1);
    busB.cmd_req = 2'b00;
    applyStimulus(8);
    busB.cmd_ack = 2'b01;
    applyStimulus(1);
    checkOutput("B_race_done", {2'b00, busB.cmd_done}, 4'b0001);
    checkOutput("B_race_err",  {2'b00, busB.cmd_err},  4'b0000);
    checkOutput("B_race_busy", {2'b00, busB.cmd_busy}, 4'b0000);
    busB.cmd_ack = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
